// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// The responder FSM states and the word-index helper live here.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_LATENCY = 4;

    // Byte address to word index: drop bit 0, keep depth_log2 bits, wrap the rest.
    function automatic logic [31:0] word_index(input logic [31:0] addr, input int depth_log2);
        return (addr >> 1) & ((32'd1 << depth_log2) - 32'd1);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Backing store: synchronous read and write, read-before-write on the same address.
// Contents are deliberately not reset.
module dmem_array #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [1 << DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: stalls the pipeline while a
// request is in flight and pulses rsp_valid for one cycle when it completes.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output state_e            dbg_state
);

    localparam int CNT_W  = $clog2(LATENCY) + 1;
    localparam bit DIRECT = (LATENCY == 1);

    state_e                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [DEPTH_LOG2-1:0] idx_q, req_idx;
    logic [DATA_W-1:0]     wdata_q;
    logic                  wr_q;
    logic                  req, accept, fire;
    logic                  arr_en, arr_we;
    logic [DEPTH_LOG2-1:0] arr_addr;
    logic [DATA_W-1:0]     arr_wdata, arr_rdata;

    assign req     = req_rd | req_wr;
    assign req_idx = DEPTH_LOG2'(word_index(32'(req_addr), DEPTH_LOG2));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (req) begin
                    stall     = 1'b1;
                    accept    = 1'b1;
                    cnt_nxt   = CNT_W'(LATENCY - 1);
                    state_nxt = DIRECT ? DONE : BUSY;
                end else begin
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                stall   = 1'b1;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                idx_q   <= req_idx;
                wdata_q <= req_wdata;
                wr_q    <= req_wr;
            end
        end
    end

    // Array access happens on the edge entering DONE. With single-cycle latency that
    // is the accept edge itself, so the live (stable) request is used instead of latches.
    // rst_n gates the enable so a request held through reset cannot commit a write.
    assign fire      = DIRECT ? accept : ((state == BUSY) && (cnt == CNT_W'(1)));
    assign arr_en    = fire && rst_n;
    assign arr_we    = DIRECT ? req_wr : wr_q;
    assign arr_addr  = DIRECT ? req_idx : idx_q;
    assign arr_wdata = DIRECT ? req_wdata : wdata_q;

    dmem_array #(
        .DATA_W    (DATA_W),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .en   (arr_en),
        .we   (arr_we),
        .addr (arr_addr),
        .wdata(arr_wdata),
        .rdata(arr_rdata)
    );

    assign rsp_valid = (state == DONE);
    assign rsp_rdata = rsp_valid ? arr_rdata : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=4 instance and a LATENCY=1 instance, each
// with a driver task and a response monitor popping an expected-data queue.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT_A = 4;

    logic        clk;
    logic        rst_n;

    logic        req_rd, req_wr;
    logic [15:0] req_addr, req_wdata;
    logic        stall, rsp_valid;
    logic [15:0] rsp_rdata;
    state_e      dbg_state;

    logic        req_rd_b, req_wr_b;
    logic [15:0] req_addr_b, req_wdata_b;
    logic        stall_b, rsp_valid_b;
    logic [15:0] rsp_rdata_b;
    state_e      dbg_state_b;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic        op_q[$];
    logic [15:0] exp_b_q[$];
    logic        op_b_q[$];

    logic [15:0] model [1024];
    logic [15:0] model_b [1024];

    dmem_responder #(.LATENCY(LAT_A)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .dbg_state(dbg_state)
    );

    dmem_responder #(.LATENCY(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_rd(req_rd_b), .req_wr(req_wr_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .stall(stall_b), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .dbg_state(dbg_state_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [15:0] addr);
        logic [15:0] a;
        a = addr >> 1;
        return int'(a & 16'h03ff);
    endfunction

    // driver for the LATENCY=4 instance; called at posedge+1 (cycle 0)
    task automatic txn_a(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic hold);
        int idx, n_stall, n_early;
        req_rd    = rd;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        idx = idx_of(addr);
        op_q.push_back(rd);
        exp_q.push_back(model[idx]);
        if (wr) model[idx] = wdata;
        n_stall = 0;
        n_early = 0;
        for (int c = 0; c < LAT_A; c++) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (c > 0 && rsp_valid) n_early++;
            if (c == 1) check("rdata_idle", 32'(rsp_rdata), 32'h0);
            @(posedge clk);
            #1;
        end
        check("stall_cycles", n_stall, LAT_A);
        check("early_rsp", n_early, 0);
        if (!hold) begin
            req_rd = 1'b0;
            req_wr = 1'b0;
            @(negedge clk);
            check("rsp_valid_lat", 32'(rsp_valid), 32'h1);
            check("stall_done", 32'(stall), 32'h0);
            @(posedge clk);
            #1;
        end
    endtask

    // driver for the LATENCY=1 instance
    task automatic txn_b(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata);
        int idx;
        req_rd_b    = rd;
        req_wr_b    = wr;
        req_addr_b  = addr;
        req_wdata_b = wdata;
        idx = idx_of(addr);
        op_b_q.push_back(rd);
        exp_b_q.push_back(model_b[idx]);
        if (wr) model_b[idx] = wdata;
        @(negedge clk);
        check("b_stall_c0", 32'(stall_b), 32'h1);
        check("b_valid_c0", 32'(rsp_valid_b), 32'h0);
        @(posedge clk);
        #1;
        req_rd_b = 1'b0;
        req_wr_b = 1'b0;
        @(negedge clk);
        check("b_valid_c1", 32'(rsp_valid_b), 32'h1);
        check("b_stall_c1", 32'(stall_b), 32'h0);
        @(posedge clk);
        #1;
    endtask

    // scoreboards
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (op_q.size() == 0) begin
                check("spurious_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                logic        op;
                logic [15:0] exp;
                op  = op_q.pop_front();
                exp = exp_q.pop_front();
                if (op) check("rsp_rdata", 32'(rsp_rdata), 32'(exp));
            end
        end
    end

    always @(negedge clk) begin
        if (rsp_valid_b) begin
            if (op_b_q.size() == 0) begin
                check("b_spurious_rsp", 32'(rsp_valid_b), 32'h0);
            end else begin
                logic        op;
                logic [15:0] exp;
                op  = op_b_q.pop_front();
                exp = exp_b_q.pop_front();
                if (op) check("b_rsp_rdata", 32'(rsp_rdata_b), 32'(exp));
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        req_rd      = 1'b0;
        req_wr      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_rd_b    = 1'b0;
        req_wr_b    = 1'b0;
        req_addr_b  = '0;
        req_wdata_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_valid", 32'(rsp_valid), 32'h0);
        check("rst_rdata", 32'(rsp_rdata), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_stall_b", 32'(stall_b), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic write then read
        txn_a(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
        txn_a(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);

        // back-to-back: read presented during the write's DONE cycle
        txn_a(1'b0, 1'b1, 16'h0020, 16'h1234, 1'b1);
        txn_a(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);

        // combined read+write returns the old word
        txn_a(1'b0, 1'b1, 16'h0030, 16'h5555, 1'b0);
        txn_a(1'b1, 1'b1, 16'h0030, 16'hAAAA, 1'b0);
        txn_a(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);

        // aliasing of upper address bits and bit 0
        txn_a(1'b0, 1'b1, 16'h0802, 16'h0F0F, 1'b0);
        txn_a(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
        txn_a(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0);

        // reset in the middle of a write aborts it
        txn_a(1'b0, 1'b1, 16'h0040, 16'h1111, 1'b0);
        req_wr    = 1'b1;
        req_addr  = 16'h0040;
        req_wdata = 16'h2222;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("busy_before_rst", 32'(dbg_state), 32'(BUSY));
        rst_n = 1'b0;
        #1;
        check("idle_after_rst", 32'(dbg_state), 32'(IDLE));
        req_wr = 1'b0;
        @(negedge clk);
        check("rst_mid_stall", 32'(stall), 32'h0);
        check("rst_mid_valid", 32'(rsp_valid), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        txn_a(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);

        // random traffic over a pre-written window
        for (int i = 0; i < 16; i++) begin
            txn_a(1'b0, 1'b1, 16'h0100 + 16'(2 * i), 16'($urandom_range(0, 65535)), 1'b0);
        end
        for (int i = 0; i < 24; i++) begin
            int op;
            logic hold;
            op   = $urandom_range(1, 3);
            hold = (i == 23) ? 1'b0 : 1'($urandom_range(0, 1));
            txn_a(1'(op & 1), 1'(op >> 1), 16'h0100 + 16'($urandom_range(0, 31)),
                  16'($urandom_range(0, 65535)), hold);
        end

        // single-cycle latency instance
        txn_b(1'b0, 1'b1, 16'h0050, 16'h7777);
        txn_b(1'b1, 1'b0, 16'h0050, 16'h0000);
        req_wr_b    = 1'b1;
        req_addr_b  = 16'h0050;
        req_wdata_b = 16'h9999;
        rst_n       = 1'b0;
        @(posedge clk);
        #1;
        req_wr_b = 1'b0;
        @(negedge clk);
        check("b_rst_valid", 32'(rsp_valid_b), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        txn_b(1'b1, 1'b0, 16'h0050, 16'h0000);
        txn_b(1'b1, 1'b1, 16'h0050, 16'h4242);
        txn_b(1'b1, 1'b0, 16'h0851, 16'h0000);

        repeat (4) @(posedge clk);
        check("a_queue_drained", exp_q.size(), 0);
        check("b_queue_drained", exp_b_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
